// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
// Bundles every signal of the M/W boundary of the pipeline.
//   M-stage side : regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM,
//                  stallM (back-pressure to the M register and earlier)
//   Data memory  : dmem_req/we/addr/wdata (request), dmem_ack/rdata (response)
//   W-stage side : regwriteW, RdW, resultW (register-file write port)
//   Status       : misalign_err, tmo_err (sticky)
// Modports: master = environment (drives M stage and memory response),
//           slave  = mem_wb_stage.
// ---------------------------------------------------------------------------
interface mem_wb_stage_if #(
    parameter int DPW = 32,
    parameter int ADW = 5
);
    logic           regwriteM;
    logic           resultsrcM;
    logic           memwriteM;
    logic [DPW-1:0] aluresultM;
    logic [DPW-1:0] Rd2M;
    logic [ADW-1:0] RdM;
    logic           stallM;

    logic           dmem_req;
    logic           dmem_we;
    logic [DPW-1:0] dmem_addr;
    logic [DPW-1:0] dmem_wdata;
    logic           dmem_ack;
    logic [DPW-1:0] dmem_rdata;

    logic           regwriteW;
    logic [ADW-1:0] RdW;
    logic [DPW-1:0] resultW;
    logic           misalign_err;
    logic           tmo_err;

    modport master (
        output regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM,
        output dmem_ack, dmem_rdata,
        input  stallM, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  regwriteW, RdW, resultW, misalign_err, tmo_err
    );

    modport slave (
        input  regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM,
        input  dmem_ack, dmem_rdata,
        output stallM, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output regwriteW, RdW, resultW, misalign_err, tmo_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Consumes the M-stage pipeline register, performs the data-memory access
// for loads/stores over a req/ack handshake, stalls upstream while the
// access is outstanding, and registers the W-stage register-file write.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_wb_stage_if.slave (M-stage inputs, stallM, dmem bus,
//              W-stage outputs, sticky error flags)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DPW = 32,
    parameter int ADW = 5,
    parameter int TMO = 15
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic           r_tmo_hit;
    logic [DPW-1:0] r_rdata;
    logic           r_req;
    logic           r_we;
    logic [DPW-1:0] r_addr;
    logic [DPW-1:0] r_wdata;
    logic           r_regwrite;
    logic [ADW-1:0] r_rd;
    logic [DPW-1:0] r_result;
    logic           r_misalign_err;
    logic           r_tmo_err;

    logic           w_memop;
    logic           w_misalign;
    logic           w_access;
    logic           w_load;
    logic           w_rd_nz;

    assign w_memop    = bus.memwriteM | bus.resultsrcM;
    assign w_misalign = w_memop & (bus.aluresultM[1:0] != 2'b00);
    assign w_access   = w_memop & ~w_misalign;
    // A store that also claims a load is treated as a store.
    assign w_load     = bus.resultsrcM & ~bus.memwriteM;
    // x0 is never written.
    assign w_rd_nz    = (bus.RdM != '0);

    // Hold upstream from the cycle an access is recognised until DONE.
    assign bus.stallM = (r_state == WAIT) | ((r_state == IDLE) & w_access);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_tmo_hit      <= 1'b0;
            r_rdata        <= '0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_regwrite     <= 1'b0;
            r_rd           <= '0;
            r_result       <= '0;
            r_misalign_err <= 1'b0;
            r_tmo_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_req      <= 1'b1;
                        r_we       <= bus.memwriteM;
                        r_addr     <= {bus.aluresultM[DPW-1:2], 2'b00};
                        r_wdata    <= bus.Rd2M;
                        r_cnt      <= '0;
                        r_tmo_hit  <= 1'b0;
                        // Bubble into W while the access is in flight.
                        r_regwrite <= 1'b0;
                        r_rd       <= '0;
                        r_result   <= '0;
                        r_state    <= WAIT;
                    end else begin
                        // Misaligned accesses are dropped and never write back.
                        r_regwrite <= bus.regwriteM & ~w_misalign & w_rd_nz;
                        r_rd       <= bus.RdM;
                        r_result   <= bus.aluresultM;
                        if (w_misalign) begin
                            r_misalign_err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // An ack in the last allowed cycle still completes normally.
                    if (bus.dmem_ack) begin
                        r_rdata <= bus.dmem_rdata;
                        r_req   <= 1'b0;
                        r_state <= DONE;
                    end else if (r_cnt == 8'(TMO - 1)) begin
                        r_rdata   <= '0;
                        r_req     <= 1'b0;
                        r_tmo_err <= 1'b1;
                        r_tmo_hit <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // Stores never write back; timed-out loads are squashed.
                    r_regwrite <= bus.regwriteM & ~bus.memwriteM & ~(w_load & r_tmo_hit) & w_rd_nz;
                    r_rd       <= bus.RdM;
                    r_result   <= w_load ? r_rdata : bus.aluresultM;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dmem_req     = r_req;
    assign bus.dmem_we      = r_we;
    assign bus.dmem_addr    = r_addr;
    assign bus.dmem_wdata   = r_wdata;
    assign bus.regwriteW    = r_regwrite;
    assign bus.RdW          = r_rd;
    assign bus.resultW      = r_result;
    assign bus.misalign_err = r_misalign_err;
    assign bus.tmo_err      = r_tmo_err;
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    localparam int DPW = 32;
    localparam int ADW = 5;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.DPW(DPW), .ADW(ADW)) bus ();

    mem_wb_stage #(.DPW(DPW), .ADW(ADW), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Sticky flags as the specification defines them.
    logic m_mis;
    logic m_tmo;

    // Observations collected by exec.
    int          ob_stall;
    int          ob_req;
    logic        ob_we;
    logic [31:0] ob_addr;
    logic [31:0] ob_wdata;
    logic        ob_stable;

    // Expected transaction outcome, derived from the instruction and the
    // memory's response delay (ack_at = WAIT cycle of the ack, 0 = never).
    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        int          stall;
        int          req;
        logic        acc;
        logic        mis;
        logic        tout;
    } exp_t;

    function automatic exp_t model(input logic rw, input logic rs, input logic mw,
                                   input logic [31:0] alu, input logic [4:0] rd,
                                   input int ack_at, input logic [31:0] rdata);
        exp_t e;
        logic memop, load, acked;
        memop  = rw === 1'bx ? 1'b0 : (mw | rs);
        load   = rs & ~mw;
        e.mis  = memop && (alu[1:0] != 2'b00);
        e.acc  = memop && !e.mis;
        acked  = (ack_at >= 1) && (ack_at <= TMO);
        e.req  = e.acc ? (acked ? ack_at : TMO) : 0;
        e.stall = e.acc ? e.req + 1 : 0;
        e.tout = e.acc && !acked;
        e.rw   = rw && (rd != 5'd0) && !e.mis && !mw && !(load && e.tout);
        e.rd   = rd;
        e.res  = (e.acc && load) ? (e.tout ? 32'd0 : rdata) : alu;
        return e;
    endfunction

    // Presents one instruction and runs the pipeline until the M register
    // advances, acting as the data memory. Returns at posedge+1 with the
    // W-stage result of that instruction visible.
    task automatic exec(input logic rw, input logic rs, input logic mw,
                        input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [4:0] rd, input int ack_at,
                        input logic [31:0] rdata, input logic stray);
        logic stall_now;
        logic done;
        bus.regwriteM  = rw;
        bus.resultsrcM = rs;
        bus.memwriteM  = mw;
        bus.aluresultM = alu;
        bus.Rd2M       = rd2;
        bus.RdM        = rd;
        ob_stall = 0; ob_req = 0; ob_stable = 1'b1;
        ob_we = 1'b0; ob_addr = '0; ob_wdata = '0;
        done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            stall_now = bus.stallM;
            if (bus.dmem_req) begin
                ob_req++;
                if (ob_req == 1) begin
                    ob_we = bus.dmem_we; ob_addr = bus.dmem_addr; ob_wdata = bus.dmem_wdata;
                end else if (ob_we !== bus.dmem_we || ob_addr !== bus.dmem_addr ||
                             ob_wdata !== bus.dmem_wdata) begin
                    ob_stable = 1'b0;
                end
                bus.dmem_ack   = (ob_req == ack_at);
                bus.dmem_rdata = (ob_req == ack_at) ? rdata : $urandom;
            end else begin
                bus.dmem_ack   = stray;
                bus.dmem_rdata = $urandom;
            end
            if (stall_now) ob_stall++;
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (!stall_now) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL exec_bound: stallM still %0b after 64 cycles, required 0", bus.stallM);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.regwriteM = 0; bus.resultsrcM = 0; bus.memwriteM = 0;
        bus.aluresultM = '0; bus.Rd2M = '0; bus.RdM = '0;
        bus.dmem_ack = 0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_dmem: got req=%0b we=%0b addr=%h wdata=%h, required all 0",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata);
        end
        checks++;
        if ({bus.regwriteW, bus.RdW, bus.resultW, bus.misalign_err, bus.tmo_err} !== '0) begin
            errors++;
            $display("FAIL reset_w: got we=%0b rd=%0d wd=%h mis=%0b tmo=%0b, required all 0",
                     bus.regwriteW, bus.RdW, bus.resultW, bus.misalign_err, bus.tmo_err);
        end
        rst = 1'b0;
        m_mis = 1'b0;
        m_tmo = 1'b0;
    endtask

    task automatic test_alu;
        // Stray acks while idle must be ignored.
        exec(1, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h0, 1'b1);
        checks++;
        if (bus.regwriteW !== 1'b1 || bus.RdW !== 5'd5 || bus.resultW !== 32'h1234) begin
            errors++;
            $display("FAIL alu_wb: got we=%0b rd=%0d wd=%h, required 1 5 00001234",
                     bus.regwriteW, bus.RdW, bus.resultW);
        end
        checks++;
        if (ob_stall !== 0 || ob_req !== 0) begin
            errors++;
            $display("FAIL alu_stall: got stall=%0d req=%0d cycles, required 0 0", ob_stall, ob_req);
        end
        exec(1, 0, 0, 32'hCAFE_0001, 32'h0, 5'd0, 0, 32'h0, 1'b0);
        checks++;
        if (bus.regwriteW !== 1'b0 || bus.resultW !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL alu_x0: got we=%0b wd=%h, required 0 cafe0001", bus.regwriteW, bus.resultW);
        end
    endtask

    task automatic test_load;
        exec(1, 1, 0, 32'h40, 32'h0, 5'd7, 3, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (ob_req !== 3 || ob_we !== 1'b0 || ob_addr !== 32'h40 || ob_stable !== 1'b1) begin
            errors++;
            $display("FAIL load_req: got req=%0d we=%0b addr=%h stable=%0b, required 3 0 00000040 1",
                     ob_req, ob_we, ob_addr, ob_stable);
        end
        checks++;
        if (ob_stall !== 4) begin
            errors++;
            $display("FAIL load_stall: got %0d stall cycles, required 4", ob_stall);
        end
        checks++;
        if (bus.regwriteW !== 1'b1 || bus.RdW !== 5'd7 || bus.resultW !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_wb: got we=%0b rd=%0d wd=%h, required 1 7 deadbeef",
                     bus.regwriteW, bus.RdW, bus.resultW);
        end
    endtask

    task automatic test_store;
        exec(0, 0, 1, 32'h80, 32'hA5A5_A5A5, 5'd3, 1, 32'h0, 1'b0);
        checks++;
        if (ob_we !== 1'b1 || ob_addr !== 32'h80 || ob_wdata !== 32'hA5A5_A5A5 || ob_req !== 1) begin
            errors++;
            $display("FAIL store_req: got we=%0b addr=%h wdata=%h req=%0d, required 1 00000080 a5a5a5a5 1",
                     ob_we, ob_addr, ob_wdata, ob_req);
        end
        checks++;
        if (bus.regwriteW !== 1'b0 || ob_stall !== 2) begin
            errors++;
            $display("FAIL store_wb: got we=%0b stall=%0d, required 0 2", bus.regwriteW, ob_stall);
        end
        // Both memwrite and resultsrc: behaves as a store, no writeback.
        exec(1, 1, 1, 32'h100, 32'h1357_9BDF, 5'd9, 2, 32'h7777_7777, 1'b0);
        checks++;
        if (ob_we !== 1'b1 || ob_wdata !== 32'h1357_9BDF || bus.regwriteW !== 1'b0) begin
            errors++;
            $display("FAIL store_both: got we=%0b wdata=%h regwriteW=%0b, required 1 13579bdf 0",
                     ob_we, ob_wdata, bus.regwriteW);
        end
    endtask

    task automatic test_ack_at_limit;
        exec(1, 1, 0, 32'h200, 32'h0, 5'd11, TMO, 32'h0BAD_F00D, 1'b0);
        checks++;
        if (bus.tmo_err !== 1'b0 || bus.regwriteW !== 1'b1 || bus.resultW !== 32'h0BAD_F00D ||
            ob_req !== TMO) begin
            errors++;
            $display("FAIL ack_limit: got tmo=%0b we=%0b wd=%h req=%0d, required 0 1 0badf00d %0d",
                     bus.tmo_err, bus.regwriteW, bus.resultW, ob_req, TMO);
        end
    endtask

    task automatic test_timeout;
        exec(1, 1, 0, 32'h300, 32'h0, 5'd12, 0, 32'h0, 1'b0);
        m_tmo = 1'b1;
        checks++;
        if (ob_req !== TMO || ob_stall !== TMO + 1) begin
            errors++;
            $display("FAIL tmo_len: got req=%0d stall=%0d, required %0d %0d", ob_req, ob_stall, TMO, TMO + 1);
        end
        checks++;
        if (bus.tmo_err !== 1'b1 || bus.regwriteW !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL tmo_flag: got tmo=%0b we=%0b req=%0b, required 1 0 0",
                     bus.tmo_err, bus.regwriteW, bus.dmem_req);
        end
    endtask

    task automatic test_misalign;
        exec(1, 1, 0, 32'h42, 32'h0, 5'd4, 1, 32'h0, 1'b0);
        m_mis = 1'b1;
        checks++;
        if (bus.misalign_err !== 1'b1 || bus.regwriteW !== 1'b0 || ob_req !== 0 || ob_stall !== 0) begin
            errors++;
            $display("FAIL misalign: got err=%0b we=%0b req=%0d stall=%0d, required 1 0 0 0",
                     bus.misalign_err, bus.regwriteW, ob_req, ob_stall);
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic rw, rs, mw, stray;
        logic [31:0] alu, rd2, rdata;
        logic [4:0] rd;
        int kind, ack_at;
        for (int n = 0; n < 40; n++) begin
            kind  = int'($urandom_range(0, 3));
            rs    = (kind == 1) || (kind == 3);
            mw    = (kind == 2) || (kind == 3);
            rw    = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            rd    = 5'($urandom_range(0, 31));
            rd2   = $urandom;
            rdata = $urandom;
            alu   = $urandom;
            if (kind != 0) begin
                alu[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            ack_at = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4));
            stray  = 1'($urandom_range(0, 1));
            e = model(rw, rs, mw, alu, rd, ack_at, rdata);
            exec(rw, rs, mw, alu, rd2, rd, ack_at, rdata, stray);
            if (e.mis) m_mis = 1'b1;
            if (e.tout) m_tmo = 1'b1;
            checks++;
            if (bus.regwriteW !== e.rw || bus.RdW !== e.rd || bus.resultW !== e.res) begin
                errors++;
                $display("FAIL rand_wb[%0d]: got we=%0b rd=%0d wd=%h, required %0b %0d %h",
                         n, bus.regwriteW, bus.RdW, bus.resultW, e.rw, e.rd, e.res);
            end
            checks++;
            if (ob_stall !== e.stall || ob_req !== e.req || ob_stable !== 1'b1 ||
                (e.acc && (ob_we !== mw || ob_addr !== {alu[31:2], 2'b00} || ob_wdata !== rd2))) begin
                errors++;
                $display("FAIL rand_mem[%0d]: got stall=%0d req=%0d we=%0b addr=%h wdata=%h, required %0d %0d %0b %h %h",
                         n, ob_stall, ob_req, ob_we, ob_addr, ob_wdata, e.stall, e.req, mw,
                         {alu[31:2], 2'b00}, rd2);
            end
            checks++;
            if (bus.misalign_err !== m_mis || bus.tmo_err !== m_tmo) begin
                errors++;
                $display("FAIL rand_err[%0d]: got mis=%0b tmo=%0b, required %0b %0b",
                         n, bus.misalign_err, bus.tmo_err, m_mis, m_tmo);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        bus.regwriteM = 1; bus.resultsrcM = 1; bus.memwriteM = 0;
        bus.aluresultM = 32'h500; bus.Rd2M = 32'h0; bus.RdM = 5'd13;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.stallM !== 1'b1) begin
            errors++;
            $display("FAIL rmw_pre: got req=%0b stall=%0b, required 1 1", bus.dmem_req, bus.stallM);
        end
        rst = 1'b1;
        bus.regwriteM = 0; bus.resultsrcM = 0; bus.aluresultM = '0; bus.RdM = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_mis = 1'b0;
        m_tmo = 1'b0;
        checks++;
        if (bus.dmem_req !== 1'b0 || bus.stallM !== 1'b0 || bus.misalign_err !== 1'b0 ||
            bus.tmo_err !== 1'b0) begin
            errors++;
            $display("FAIL rmw_reset: got req=%0b stall=%0b mis=%0b tmo=%0b, required 0 0 0 0",
                     bus.dmem_req, bus.stallM, bus.misalign_err, bus.tmo_err);
        end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.regwriteW, bus.RdW,
             bus.resultW, bus.misalign_err, bus.tmo_err, bus.stallM} !== '0) begin
            errors++;
            $display("FAIL rmw_late_ack: got req=%0b we=%0b addr=%h wdata=%h rw=%0b rd=%0d wd=%h mis=%0b tmo=%0b stall=%0b, required all 0",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.regwriteW,
                     bus.RdW, bus.resultW, bus.misalign_err, bus.tmo_err, bus.stallM);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_ack_at_limit();
        test_timeout();
        test_misalign();
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
